// File: rtl/bus_rr_arbiter_mux.sv
// bus_rr_arbiter_mux
// Round-robin bus arbiter with hold-limit preemption and master-side mux.
// The grant is registered. The granted master's address, strobe, read/write
// and write data are driven onto the shared slave-side bus.
//
// Ports:
//   clk        system clock
//   reset_     asynchronous active-low reset
//   m_req_     per-master bus request, active-low
//   m_addr     packed master addresses, master i at [i*ADDR_W +: ADDR_W]
//   m_as_      per-master address strobe, active-low
//   m_rw       per-master read(1)/write(0)
//   m_wr_data  packed master write data, master i at [i*DATA_W +: DATA_W]
//   s_rdy_     slave ready, active-low; ends the current access
//   m_grnt_    per-master grant, active-low, registered, at most one low
//   s_addr     muxed address (0 when idle)
//   s_as_      muxed address strobe (1 when idle)
//   s_rw       muxed read/write (1 = read when idle)
//   s_wr_data  muxed write data (0 when idle)
//   bus_busy   high while a grant is held
//   owner_id   index of the current owner, 0 when idle
module bus_rr_arbiter_mux #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int MAX_HOLD  = 16,
  parameter int CNT_W     = 5
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic [N_MASTERS-1:0]          m_req_,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS-1:0]          m_as_,
  input  logic [N_MASTERS-1:0]          m_rw,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wr_data,
  input  logic                          s_rdy_,
  output logic [N_MASTERS-1:0]          m_grnt_,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data,
  output logic                          bus_busy,
  output logic [$clog2(N_MASTERS)-1:0]  owner_id
);

  localparam int ID_W = $clog2(N_MASTERS);
  localparam logic [CNT_W-1:0] HOLD_LIM = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_MASTERS - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t               state, state_nx;
  logic [ID_W-1:0]      owner, owner_nx;
  logic [ID_W-1:0]      ptr, ptr_nx;
  logic [ID_W-1:0]      sel, sel_inc;
  logic [CNT_W-1:0]     hold_cnt, hold_cnt_nx;
  logic [N_MASTERS-1:0] grnt_nx;
  logic                 any_req, other_req, release_own, access_open, preempt;

  // Round-robin search starting at ptr. While a master owns the bus ptr is
  // always owner+1, so the current owner is the last candidate examined and
  // a preemption can never re-select it while another master is requesting.
  always_comb begin
    logic [ID_W:0] idx_w;
    idx_w   = '0;
    sel     = '0;
    any_req = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      idx_w = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx_w >= (ID_W+1)'(N_MASTERS))
        idx_w = idx_w - (ID_W+1)'(N_MASTERS);
      if (!any_req && !m_req_[idx_w[ID_W-1:0]]) begin
        any_req = 1'b1;
        sel     = idx_w[ID_W-1:0];
      end
    end
  end

  assign sel_inc = (sel == LAST_ID) ? '0 : sel + 1'b1;

  // Owner status used by the next-state logic.
  always_comb begin
    logic [N_MASTERS-1:0] others;
    others        = ~m_req_;
    others[owner] = 1'b0;
    other_req     = |others;
    release_own   = m_req_[owner];
    access_open   = !m_as_[owner] && s_rdy_;
    preempt       = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LIM) && other_req && !access_open;
  end

  // State register; the grant vector is registered alongside it.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      m_grnt_  <= '1;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_cnt_nx;
      m_grnt_  <= grnt_nx;
    end
  end

  // Next-state logic. Release and preemption share one path, which makes a
  // simultaneous release+preempt behave as a release.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    ptr_nx      = ptr;
    hold_cnt_nx = hold_cnt;
    grnt_nx     = m_grnt_;
    unique case (state)
      IDLE: begin
        hold_cnt_nx = '0;
        if (any_req) begin
          state_nx      = OWN;
          owner_nx      = sel;
          ptr_nx        = sel_inc;
          grnt_nx       = '1;
          grnt_nx[sel]  = 1'b0;
        end
      end
      OWN: begin
        if (release_own || preempt) begin
          hold_cnt_nx = '0;
          if (any_req) begin
            owner_nx     = sel;
            ptr_nx       = sel_inc;
            grnt_nx      = '1;
            grnt_nx[sel] = 1'b0;
          end else begin
            state_nx = IDLE;
            owner_nx = '0;
            grnt_nx  = '1;
          end
        end else if (hold_cnt < HOLD_LIM) begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output logic: slave-side mux driven only from the registered owner.
  always_comb begin
    bus_busy  = (state == OWN);
    owner_id  = '0;
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (state == OWN) begin
      owner_id  = owner;
      s_addr    = m_addr[owner*ADDR_W +: ADDR_W];
      s_as_     = m_as_[owner];
      s_rw      = m_rw[owner];
      s_wr_data = m_wr_data[owner*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter_mux.sv
// Testbench for bus_rr_arbiter_mux: directed scenarios plus randomized
// traffic checked against a cycle-level reference model. Two instances
// share all inputs: dut (MAX_HOLD=4) and dut0 (MAX_HOLD=0).
module tb_bus_rr_arbiter_mux;
  localparam int N  = 4;
  localparam int AW = 30;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset_;
  logic [N-1:0]    req_n, as_n, rw;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic            s_rdy_;

  logic [N-1:0]  grnt_a, grnt_b;
  logic [AW-1:0] saddr_a, saddr_b;
  logic          sas_a, sas_b, srw_a, srw_b, busy_a, busy_b;
  logic [DW-1:0] swd_a, swd_b;
  logic [1:0]    oid_a, oid_b;

  logic [N-1:0]  grnt_v [2];
  logic [AW-1:0] saddr_v [2];
  logic          sas_v [2];
  logic          srw_v [2];
  logic          busy_v [2];
  logic [DW-1:0] swd_v [2];
  logic [1:0]    oid_v [2];

  assign grnt_v[0] = grnt_a;   assign grnt_v[1] = grnt_b;
  assign saddr_v[0] = saddr_a; assign saddr_v[1] = saddr_b;
  assign sas_v[0] = sas_a;     assign sas_v[1] = sas_b;
  assign srw_v[0] = srw_a;     assign srw_v[1] = srw_b;
  assign busy_v[0] = busy_a;   assign busy_v[1] = busy_b;
  assign swd_v[0] = swd_a;     assign swd_v[1] = swd_b;
  assign oid_v[0] = oid_a;     assign oid_v[1] = oid_b;

  int vectors = 0;
  int miscompares = 0;

  bus_rr_arbiter_mux #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4), .CNT_W(5)) dut (
    .clk(clk), .reset_(reset_), .m_req_(req_n), .m_addr(addr), .m_as_(as_n), .m_rw(rw),
    .m_wr_data(wdata), .s_rdy_(s_rdy_), .m_grnt_(grnt_a), .s_addr(saddr_a), .s_as_(sas_a),
    .s_rw(srw_a), .s_wr_data(swd_a), .bus_busy(busy_a), .owner_id(oid_a));

  bus_rr_arbiter_mux #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(0), .CNT_W(5)) dut0 (
    .clk(clk), .reset_(reset_), .m_req_(req_n), .m_addr(addr), .m_as_(as_n), .m_rw(rw),
    .m_wr_data(wdata), .s_rdy_(s_rdy_), .m_grnt_(grnt_b), .s_addr(saddr_b), .s_as_(sas_b),
    .s_rw(srw_b), .s_wr_data(swd_b), .bus_busy(busy_b), .owner_id(oid_b));

  always #5 clk = ~clk;

  // Reference model: owner (-1 = idle), search pointer, cycles owned so far.
  int m_own [2];
  int m_ptr [2];
  int m_held [2];
  int lim [2];

  function automatic int search(int p, logic [N-1:0] rq);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (p + k) % N;
      if (!rq[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] e_grnt(int o);
    logic [N-1:0] g;
    g = '1;
    if (o >= 0) g[o] = 1'b0;
    return g;
  endfunction

  function automatic logic [AW-1:0] e_addr(int o);
    return (o < 0) ? '0 : addr[o*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] e_wd(int o);
    return (o < 0) ? '0 : wdata[o*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1; m_ptr[d] = 0; m_held[d] = 0;
    end
  endtask

  // Computes the model's next state from the inputs present before the edge,
  // then advances to 1 time unit after the rising edge.
  task automatic tick();
    int no [2];
    int np [2];
    int nh [2];
    for (int d = 0; d < 2; d++) begin
      int s;
      bit rel, others, outstanding, pre;
      no[d] = m_own[d]; np[d] = m_ptr[d]; nh[d] = m_held[d];
      if (m_own[d] < 0) begin
        s = search(m_ptr[d], req_n);
        if (s >= 0) begin no[d] = s; np[d] = (s + 1) % N; nh[d] = 1; end
      end else begin
        rel = req_n[m_own[d]];
        others = 1'b0;
        for (int i = 0; i < N; i++) if (i != m_own[d] && !req_n[i]) others = 1'b1;
        outstanding = !as_n[m_own[d]] && s_rdy_;
        pre = (lim[d] != 0) && (m_held[d] >= lim[d]) && others && !outstanding;
        if (rel || pre) begin
          s = search((m_own[d] + 1) % N, req_n);
          if (s >= 0) begin no[d] = s; np[d] = (s + 1) % N; nh[d] = 1; end
          else begin no[d] = -1; np[d] = (m_own[d] + 1) % N; nh[d] = 0; end
        end else begin
          nh[d] = m_held[d] + 1;
        end
      end
    end
    @(posedge clk); #1;
    m_own = no; m_ptr = np; m_held = nh;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    req_n = '1; as_n = '1; rw = '1; s_rdy_ = 1'b1;
    #2;
    model_reset();
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    req_n = '0; as_n = '1; rw = '1; s_rdy_ = 1'b1;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW] = AW'($urandom);
      wdata[i*DW +: DW] = $urandom;
    end
    model_reset();
    @(posedge clk); #1;
    vectors++; if (grnt_a !== 4'b1111) begin miscompares++; $display("FAIL reset_grnt: got %b expected 1111", grnt_a); end
    vectors++; if (grnt_b !== 4'b1111) begin miscompares++; $display("FAIL reset_grnt0: got %b expected 1111", grnt_b); end
    vectors++; if (sas_a !== 1'b1) begin miscompares++; $display("FAIL reset_s_as: got %b expected 1", sas_a); end
    vectors++; if (srw_a !== 1'b1) begin miscompares++; $display("FAIL reset_s_rw: got %b expected 1", srw_a); end
    vectors++; if (saddr_a !== '0) begin miscompares++; $display("FAIL reset_s_addr: got %h expected 0", saddr_a); end
    vectors++; if (swd_a !== '0) begin miscompares++; $display("FAIL reset_s_wr_data: got %h expected 0", swd_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    vectors++; if (oid_a !== 2'd0) begin miscompares++; $display("FAIL reset_owner: got %0d expected 0", oid_a); end
    @(negedge clk);
    reset_ = 1'b1;
    tick();
    vectors++; if (grnt_a !== 4'b1110) begin miscompares++; $display("FAIL first_grant: got %b expected 1110", grnt_a); end
    vectors++; if (grnt_b !== 4'b1110) begin miscompares++; $display("FAIL first_grant0: got %b expected 1110", grnt_b); end
  endtask

  task automatic test_round_robin();
    int cur;
    do_reset();
    req_n = '0;
    tick();
    vectors++; if (grnt_a !== 4'b1110) begin miscompares++; $display("FAIL rr_start: got %b expected 1110", grnt_a); end
    cur = 0;
    for (int i = 1; i <= 5; i++) begin
      req_n = '0;
      req_n[cur] = 1'b1;
      tick();
      cur = i % N;
      vectors++; if (grnt_a !== e_grnt(cur)) begin miscompares++; $display("FAIL rr_grant step %0d: got %b expected %b", i, grnt_a, e_grnt(cur)); end
      vectors++; if (oid_a !== 2'(cur)) begin miscompares++; $display("FAIL rr_owner step %0d: got %0d expected %0d", i, oid_a, cur); end
      vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL rr_no_gap step %0d: got %b expected 1", i, busy_a); end
    end
  endtask

  task automatic test_mux_routing();
    do_reset();
    req_n = 4'b1011;
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW] = AW'($urandom) | AW'(1);
      wdata[i*DW +: DW] = $urandom;
    end
    tick();
    vectors++; if (grnt_a !== 4'b1011) begin miscompares++; $display("FAIL mux_grant: got %b expected 1011", grnt_a); end
    addr[2*AW +: AW] = 30'h0000_1234;
    wdata[2*DW +: DW] = 32'hDEAD_BEEF;
    as_n = 4'b1011;
    rw = 4'b1011;
    #1;
    vectors++; if (saddr_a !== 30'h0000_1234) begin miscompares++; $display("FAIL mux_addr: got %h expected 00001234", saddr_a); end
    vectors++; if (sas_a !== 1'b0) begin miscompares++; $display("FAIL mux_as: got %b expected 0", sas_a); end
    vectors++; if (srw_a !== 1'b0) begin miscompares++; $display("FAIL mux_rw: got %b expected 0", srw_a); end
    vectors++; if (swd_a !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mux_wr_data: got %h expected deadbeef", swd_a); end
    as_n = 4'b0100;
    rw = 4'b0100;
    #1;
    vectors++; if (sas_a !== 1'b1) begin miscompares++; $display("FAIL mux_as_leak: got %b expected 1", sas_a); end
    vectors++; if (srw_a !== 1'b1) begin miscompares++; $display("FAIL mux_rw_leak: got %b expected 1", srw_a); end
    as_n = '1;
    rw = '1;
  endtask

  task automatic test_preemption();
    do_reset();
    req_n = 4'b1110;
    tick();
    req_n = 4'b1100;
    for (int i = 2; i <= 4; i++) begin
      tick();
      vectors++; if (grnt_a !== 4'b1110) begin miscompares++; $display("FAIL preempt_hold cycle %0d: got %b expected 1110", i, grnt_a); end
    end
    tick();
    vectors++; if (grnt_a !== 4'b1101) begin miscompares++; $display("FAIL preempt_switch: got %b expected 1101", grnt_a); end
    vectors++; if (grnt_b !== 4'b1110) begin miscompares++; $display("FAIL preempt_disabled: got %b expected 1110", grnt_b); end
    as_n = 4'b1101;
    s_rdy_ = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++; if (grnt_a !== 4'b1101) begin miscompares++; $display("FAIL preempt_deferred cycle %0d: got %b expected 1101", i, grnt_a); end
    end
    s_rdy_ = 1'b0;
    tick();
    vectors++; if (grnt_a !== 4'b1110) begin miscompares++; $display("FAIL preempt_after_rdy: got %b expected 1110", grnt_a); end
    s_rdy_ = 1'b1;
    as_n = '1;
  endtask

  task automatic test_no_preempt();
    int bad;
    do_reset();
    req_n = 4'b1110;
    tick();
    req_n = 4'b0110;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      vectors++; if (grnt_b !== 4'b1110) begin miscompares++; $display("FAIL hold0_keep cycle %0d: got %b expected 1110", i, grnt_b); end
    end
    req_n = 4'b0111;
    tick();
    vectors++; if (grnt_b !== 4'b0111) begin miscompares++; $display("FAIL hold0_release: got %b expected 0111", grnt_b); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_n = 4'b1101;
    tick();
    vectors++; if (grnt_a !== 4'b1101) begin miscompares++; $display("FAIL areset_pre_grant: got %b expected 1101", grnt_a); end
    as_n = 4'b1101;
    #1;
    vectors++; if (sas_a !== 1'b0) begin miscompares++; $display("FAIL areset_pre_as: got %b expected 0", sas_a); end
    reset_ = 1'b0;
    #1;
    vectors++; if (grnt_a !== 4'b1111) begin miscompares++; $display("FAIL areset_grant: got %b expected 1111", grnt_a); end
    vectors++; if (sas_a !== 1'b1) begin miscompares++; $display("FAIL areset_as: got %b expected 1", sas_a); end
    vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b expected 0", busy_a); end
    model_reset();
    as_n = '1;
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  task automatic test_random();
    int o;
    do_reset();
    req_n = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) req_n[i] = ~req_n[i];
      as_n = 4'($urandom);
      rw = 4'($urandom);
      s_rdy_ = 1'($urandom_range(1));
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW] = AW'($urandom);
        wdata[i*DW +: DW] = $urandom;
      end
      tick();
      for (int d = 0; d < 2; d++) begin
        o = m_own[d];
        vectors++; if (grnt_v[d] !== e_grnt(o)) begin miscompares++; $display("FAIL rand_grant dut%0d cyc %0d: got %b expected %b", d, c, grnt_v[d], e_grnt(o)); end
        vectors++; if (busy_v[d] !== (o >= 0)) begin miscompares++; $display("FAIL rand_busy dut%0d cyc %0d: got %b expected %b", d, c, busy_v[d], (o >= 0)); end
        vectors++; if (oid_v[d] !== 2'((o < 0) ? 0 : o)) begin miscompares++; $display("FAIL rand_owner dut%0d cyc %0d: got %0d expected %0d", d, c, oid_v[d], (o < 0) ? 0 : o); end
        vectors++; if (saddr_v[d] !== e_addr(o)) begin miscompares++; $display("FAIL rand_addr dut%0d cyc %0d: got %h expected %h", d, c, saddr_v[d], e_addr(o)); end
        vectors++; if (sas_v[d] !== ((o < 0) ? 1'b1 : as_n[o])) begin miscompares++; $display("FAIL rand_as dut%0d cyc %0d: got %b", d, c, sas_v[d]); end
        vectors++; if (srw_v[d] !== ((o < 0) ? 1'b1 : rw[o])) begin miscompares++; $display("FAIL rand_rw dut%0d cyc %0d: got %b", d, c, srw_v[d]); end
        vectors++; if (swd_v[d] !== e_wd(o)) begin miscompares++; $display("FAIL rand_wr_data dut%0d cyc %0d: got %h expected %h", d, c, swd_v[d], e_wd(o)); end
      end
    end
  endtask

  initial begin
    lim[0] = 4;
    lim[1] = 0;
    reset_ = 1'b0;
    req_n = '1; as_n = '1; rw = '1; s_rdy_ = 1'b1;
    addr = '0; wdata = '0;
    model_reset();
    test_reset();
    test_round_robin();
    test_mux_routing();
    test_preemption();
    test_no_preempt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
